// File: rtl/alu_op_sequencer.sv
// alu_op_sequencer: registers one request at a time into the ALU inputs,
// allows a full settle cycle, then holds the captured result and flags
// until the consumer takes them. It also keeps the committed status flags
// and a count of completed operations.
module alu_op_sequencer #(
  parameter int COUNT_W = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               req_valid,
  output logic               req_ready,
  input  logic [3:0]         req_op,
  input  logic [7:0]         req_a,
  input  logic [7:0]         req_b,
  output logic               rsp_valid,
  input  logic               rsp_ready,
  output logic [7:0]         rsp_result,
  output logic [3:0]         rsp_flags,
  output logic [3:0]         alu_operation,
  output logic [7:0]         alu_operand1,
  output logic [7:0]         alu_operand2,
  input  logic [7:0]         alu_result,
  input  logic               alu_zero_flag,
  input  logic               alu_carry_flag,
  input  logic               alu_overflow_flag,
  input  logic               alu_negative_flag,
  output logic [3:0]         status_flags,
  output logic [COUNT_W-1:0] op_count
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state;
  state_t next_state;
  logic   accept;
  logic   consume;

  // State register; reset discards any in-flight operation.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next state and handshakes; a consumed response frees the slot in the
  // same cycle, so req_ready follows rsp_ready combinationally in DONE.
  always_comb begin
    next_state = state;
    req_ready  = 1'b0;
    rsp_valid  = 1'b0;
    accept     = 1'b0;
    consume    = 1'b0;
    case (state)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          accept     = 1'b1;
          next_state = EXEC;
        end
      end
      EXEC: begin
        next_state = DONE;
      end
      DONE: begin
        rsp_valid = 1'b1;
        if (rsp_ready) begin
          consume   = 1'b1;
          req_ready = 1'b1;
          if (req_valid) begin
            accept     = 1'b1;
            next_state = EXEC;
          end else begin
            next_state = IDLE;
          end
        end
      end
      default: begin
        next_state = IDLE;
      end
    endcase
  end

  // ALU drive registers load only on acceptance and otherwise hold,
  // so the ALU sees stable inputs through EXEC and DONE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alu_operation <= 4'd0;
      alu_operand1  <= 8'd0;
      alu_operand2  <= 8'd0;
    end else if (accept) begin
      alu_operation <= req_op;
      alu_operand1  <= req_a;
      alu_operand2  <= req_b;
    end
  end

  // Response capture at the end of the settle cycle; flags packed {N,O,C,Z}.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_result <= 8'd0;
      rsp_flags  <= 4'd0;
    end else if (state == EXEC) begin
      rsp_result <= alu_result;
      rsp_flags  <= {alu_negative_flag, alu_overflow_flag,
                     alu_carry_flag, alu_zero_flag};
    end
  end

  // Status flags and the operation counter commit only when a response
  // is actually taken; the counter wraps silently.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      status_flags <= 4'd0;
      op_count     <= '0;
    end else if (consume) begin
      status_flags <= rsp_flags;
      op_count     <= op_count + COUNT_W'(1);
    end
  end

endmodule

// File: tb/tb_alu_op_sequencer.sv
// tb_alu_op_sequencer: directed and randomized checks of the sequencer
// against a transaction-level model, with a behavioural ALU attached to
// the drive/return ports.
module tb_alu_op_sequencer;

  localparam int CW = 4;

  localparam logic [3:0] OP_ADD = 4'd0;
  localparam logic [3:0] OP_SUB = 4'd1;
  localparam logic [3:0] OP_AND = 4'd2;
  localparam logic [3:0] OP_OR  = 4'd3;
  localparam logic [3:0] OP_XOR = 4'd4;

  logic          clk;
  logic          rst_n;
  logic          req_valid;
  logic          req_ready;
  logic [3:0]    req_op;
  logic [7:0]    req_a;
  logic [7:0]    req_b;
  logic          rsp_valid;
  logic          rsp_ready;
  logic [7:0]    rsp_result;
  logic [3:0]    rsp_flags;
  logic [3:0]    alu_operation;
  logic [7:0]    alu_operand1;
  logic [7:0]    alu_operand2;
  logic [7:0]    alu_result;
  logic          alu_zero_flag;
  logic          alu_carry_flag;
  logic          alu_overflow_flag;
  logic          alu_negative_flag;
  logic [3:0]    status_flags;
  logic [CW-1:0] op_count;
  logic [11:0]   alu_bus;

  int checks;
  int failures;

  // model state
  int            cyc;
  int            acc_cyc;
  bit            have_op;
  logic [3:0]    m_op;
  logic [7:0]    m_a;
  logic [7:0]    m_b;
  logic [11:0]   m_rsp;
  logic [3:0]    m_status;
  logic [CW-1:0] m_count;

  alu_op_sequencer #(.COUNT_W(CW)) dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .req_valid         (req_valid),
    .req_ready         (req_ready),
    .req_op            (req_op),
    .req_a             (req_a),
    .req_b             (req_b),
    .rsp_valid         (rsp_valid),
    .rsp_ready         (rsp_ready),
    .rsp_result        (rsp_result),
    .rsp_flags         (rsp_flags),
    .alu_operation     (alu_operation),
    .alu_operand1      (alu_operand1),
    .alu_operand2      (alu_operand2),
    .alu_result        (alu_result),
    .alu_zero_flag     (alu_zero_flag),
    .alu_carry_flag    (alu_carry_flag),
    .alu_overflow_flag (alu_overflow_flag),
    .alu_negative_flag (alu_negative_flag),
    .status_flags      (status_flags),
    .op_count          (op_count)
  );

  // behavioural ALU: returns {N,O,C,Z,result[7:0]}
  function automatic logic [11:0] alu_fn(input logic [3:0] op,
                                         input logic [7:0] a,
                                         input logic [7:0] b);
    logic [8:0] w;
    logic [7:0] r;
    logic       c;
    logic       o;
    w = 9'd0;
    c = 1'b0;
    o = 1'b0;
    case (op)
      OP_ADD: begin
        w = {1'b0, a} + {1'b0, b};
        r = w[7:0];
        c = w[8];
        o = (a[7] == b[7]) && (r[7] != a[7]);
      end
      OP_SUB: begin
        w = {1'b0, a} - {1'b0, b};
        r = w[7:0];
        c = ~w[8];
        o = (a[7] != b[7]) && (r[7] != a[7]);
      end
      OP_AND:  r = a & b;
      OP_OR:   r = a | b;
      OP_XOR:  r = a ^ b;
      default: r = ~a;
    endcase
    return {r[7], o, c, (r == 8'd0), r};
  endfunction

  assign alu_bus           = alu_fn(alu_operation, alu_operand1, alu_operand2);
  assign alu_result        = alu_bus[7:0];
  assign alu_zero_flag     = alu_bus[8];
  assign alu_carry_flag    = alu_bus[9];
  assign alu_overflow_flag = alu_bus[10];
  assign alu_negative_flag = alu_bus[11];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs,
                             input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock cycle: drive inputs, check every output against the model,
  // then advance the model across the edge.
  task automatic applyStimulus(input logic rv, input logic [3:0] op,
                               input logic [7:0] a, input logic [7:0] b,
                               input logic rr);
    bit exp_valid;
    bit exp_ready;
    bit do_consume;
    bit do_accept;
    req_valid = rv;
    req_op    = op;
    req_a     = a;
    req_b     = b;
    rsp_ready = rr;
    #1;
    exp_valid = have_op && ((cyc - acc_cyc) >= 2);
    exp_ready = !have_op || (exp_valid && rr);
    checkOutput("req_ready", req_ready, exp_ready);
    checkOutput("rsp_valid", rsp_valid, exp_valid);
    if (exp_valid) begin
      checkOutput("rsp_result", rsp_result, m_rsp[7:0]);
      checkOutput("rsp_flags", rsp_flags, m_rsp[11:8]);
    end
    checkOutput("alu_operation", alu_operation, m_op);
    checkOutput("alu_operand1", alu_operand1, m_a);
    checkOutput("alu_operand2", alu_operand2, m_b);
    checkOutput("status_flags", status_flags, m_status);
    checkOutput("op_count", op_count, m_count);
    do_consume = exp_valid && rr;
    do_accept  = rv && exp_ready;
    if (do_consume) begin
      m_status = m_rsp[11:8];
      m_count  = m_count + 1'b1;
      have_op  = 1'b0;
    end
    if (do_accept) begin
      have_op = 1'b1;
      acc_cyc = cyc;
      m_op    = op;
      m_a     = a;
      m_b     = b;
      m_rsp   = alu_fn(op, a, b);
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  // Asynchronous reset pulse starting mid-cycle; outputs must clear at once.
  task automatic applyResetPulse();
    req_valid = 1'b0;
    rsp_ready = 1'b0;
    rst_n     = 1'b0;
    #1;
    checkOutput("rst_req_ready", req_ready, 1'b1);
    checkOutput("rst_rsp_valid", rsp_valid, 1'b0);
    checkOutput("rst_rsp_result", rsp_result, 8'd0);
    checkOutput("rst_rsp_flags", rsp_flags, 4'd0);
    checkOutput("rst_alu_operation", alu_operation, 4'd0);
    checkOutput("rst_alu_operand1", alu_operand1, 8'd0);
    checkOutput("rst_alu_operand2", alu_operand2, 8'd0);
    checkOutput("rst_status_flags", status_flags, 4'd0);
    checkOutput("rst_op_count", op_count, 0);
    have_op  = 1'b0;
    m_op     = 4'd0;
    m_a      = 8'd0;
    m_b      = 8'd0;
    m_rsp    = 12'd0;
    m_status = 4'd0;
    m_count  = '0;
    repeat (2) @(posedge clk);
    #2;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  // Single operation with hand-derived expected result and flags.
  task automatic runOp(input string tag, input logic [3:0] op,
                       input logic [7:0] a, input logic [7:0] b,
                       input logic [7:0] exp_res, input logic [3:0] exp_flags);
    applyStimulus(1'b1, op, a, b, 1'b0);
    applyStimulus(1'b0, 4'd0, 8'd0, 8'd0, 1'b0);
    checkOutput({tag, "_valid"}, rsp_valid, 1'b1);
    checkOutput({tag, "_result"}, rsp_result, exp_res);
    checkOutput({tag, "_flags"}, rsp_flags, exp_flags);
    applyStimulus(1'b0, 4'd0, 8'd0, 8'd0, 1'b1);
  endtask

  initial begin
    checks    = 0;
    failures  = 0;
    cyc       = 0;
    acc_cyc   = 0;
    rst_n     = 1'b1;
    req_valid = 1'b0;
    req_op    = 4'd0;
    req_a     = 8'd0;
    req_b     = 8'd0;
    rsp_ready = 1'b0;
    @(posedge clk);
    #1;
    applyResetPulse();

    $display("[TB] directed operations");
    runOp("add_10_5", OP_ADD, 8'd10, 8'd5, 8'd15, 4'b0000);
    checkOutput("count_after_first", op_count, 1);
    checkOutput("status_after_first", status_flags, 4'b0000);
    runOp("add_255_1", OP_ADD, 8'd255, 8'd1, 8'd0, 4'b0011);
    checkOutput("status_after_carry", status_flags, 4'b0011);
    runOp("add_127_1", OP_ADD, 8'd127, 8'd1, 8'd128, 4'b1100);
    runOp("sub_10_5", OP_SUB, 8'd10, 8'd5, 8'd5, 4'b0010);
    runOp("sub_0_1", OP_SUB, 8'd0, 8'd1, 8'd255, 4'b1000);
    runOp("xor_ff_ff", OP_XOR, 8'hFF, 8'hFF, 8'h00, 4'b0001);
    runOp("and_aa_f0", OP_AND, 8'hAA, 8'hF0, 8'hA0, 4'b1000);
    checkOutput("count_after_directed", op_count, 7);

    $display("[TB] backpressure");
    applyStimulus(1'b1, OP_ADD, 8'd3, 8'd4, 1'b0);
    applyStimulus(1'b1, OP_SUB, 8'd9, 8'd2, 1'b0);
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1'b1, OP_SUB, 8'd9, 8'd2, 1'b0);
    end
    checkOutput("bp_result_held", rsp_result, 8'd7);
    checkOutput("bp_drive_held", alu_operand1, 8'd3);
    applyStimulus(1'b1, OP_SUB, 8'd9, 8'd2, 1'b1);
    applyStimulus(1'b0, 4'd0, 8'd0, 8'd0, 1'b0);
    checkOutput("bp_next_valid", rsp_valid, 1'b1);
    checkOutput("bp_next_result", rsp_result, 8'd7);
    checkOutput("bp_next_drive", alu_operation, OP_SUB);
    applyStimulus(1'b0, 4'd0, 8'd0, 8'd0, 1'b1);

    $display("[TB] back-to-back stream");
    applyResetPulse();
    for (int i = 0; i < 9; i++) begin
      applyStimulus((i < 8), OP_ADD, 8'(10 * (i / 2 + 1)), 8'd1, 1'b1);
    end
    checkOutput("stream_count", op_count, 4);
    checkOutput("stream_last_drive", alu_operand1, 8'd40);

    $display("[TB] reset during EXEC");
    applyStimulus(1'b1, OP_ADD, 8'd1, 8'd2, 1'b0);
    applyResetPulse();
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b0, 4'd0, 8'd0, 8'd0, 1'b1);
    end
    runOp("after_reset", OP_ADD, 8'd20, 8'd22, 8'd42, 4'b0000);
    checkOutput("after_reset_count", op_count, 1);

    $display("[TB] randomized traffic");
    for (int i = 0; i < 400; i++) begin
      applyStimulus(($urandom_range(0, 3) != 0), 4'($urandom_range(0, 15)),
                    8'($urandom), 8'($urandom), ($urandom_range(0, 2) != 0));
    end
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b0, 4'd0, 8'd0, 8'd0, 1'b1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
